// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the 10001 pattern transmitter
// and its matching sequence detector.
package seq_pkg;

    localparam int         PAT_W_DEF = 5;
    localparam logic [4:0] SEQ_10001 = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_10001.sv
// Serial pattern transmitter: sends N frames of PATTERN MSB-first, either as
// full frames or overlapped (shared end/start bit), then pulses done.
module seq_gen_10001
    import seq_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = SEQ_10001,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             overlap,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 2);

    // Overlapped frames reuse the last bit as the next frame's first bit,
    // which only makes sense when the pattern starts and ends alike.
    generate
        if (PATTERN[PAT_W-1] != PATTERN[0]) begin : g_overlap_check
            $error("seq_gen_10001: overlap mode needs PATTERN MSB == LSB");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] frames_left;
    logic             ovl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = SEND;
                SEND: if (idx == '0 && frames_left <= CNT_W'(1)) state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Bit index and frame counter; configuration is frozen at start so
    // input changes mid-transmission are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            frames_left <= '0;
            ovl_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx         <= IDX_TOP;
                        frames_left <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                        ovl_q       <= overlap;
                    end
                end
                SEND: begin
                    if (!abort) begin
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                        end else if (frames_left > CNT_W'(1)) begin
                            frames_left <= frames_left - 1'b1;
                            idx         <= ovl_q ? IDX_OVL : IDX_TOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out       = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            SEND: begin
                out       = PATTERN[idx];
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_gen_10001.sv
// Self-checking bench for seq_gen_10001: table-driven transmissions plus
// hand-written reset, abort and start/abort-collision sequences.
module tb_seq_gen_10001;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] repeat_n;
    logic       overlap;
    logic       abort;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Expected {out, out_valid, busy, done} per cycle, in order.
    logic [3:0] expQ[$];

    typedef struct {
        logic [3:0]  rn;
        logic        ov;
        int          len;
        logic [63:0] bits;
        int          midStart;
    } vec_t;

    vec_t vecs[7];

    seq_gen_10001 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .repeat_n  (repeat_n),
        .overlap   (overlap),
        .abort     (abort),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name);
        logic [3:0] exp;
        logic [3:0] act;
        act = {out, out_valid, busy, done};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got out/valid/busy/done=%b", name, act);
        end else begin
            exp = expQ.pop_front();
            if (act !== exp) begin
                errors++;
                $display("[TB] FAIL %s: out/valid/busy/done got %b expected %b at %0t",
                         name, act, exp, $time);
            end
        end
    endtask

    // Starts one transmission and checks every cycle through the return to IDLE.
    task automatic applyStimulus(input vec_t v, input string name);
        @(negedge clk);
        start    = 1'b1;
        repeat_n = v.rn;
        overlap  = v.ov;
        abort    = 1'b0;
        for (int i = 0; i < v.len; i++) expQ.push_back({v.bits[v.len-1-i], 3'b110});
        expQ.push_back(4'b0011);
        expQ.push_back(4'b0000);
        for (int c = 1; c <= v.len + 2; c++) begin
            @(negedge clk);
            checkOutput(name);
            start    = (c == v.midStart);
            repeat_n = 4'($urandom);
            overlap  = 1'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd1,  1'b0, 5,  64'b10001,           0};
        vecs[1] = '{4'd3,  1'b0, 15, 64'b100011000110001, 0};
        vecs[2] = '{4'd3,  1'b1, 13, 64'b1000100010001,   0};
        vecs[3] = '{4'd0,  1'b0, 5,  64'b10001,           3};
        vecs[4] = '{4'd2,  1'b1, 9,  64'b100010001,       4};
        vecs[5] = '{4'd0,  1'b1, 5,  64'b10001,           0};
        vecs[6] = '{4'd2,  1'b0, 10, 64'b1000110001,      7};

        rst      = 1'b0;
        start    = 1'b0;
        repeat_n = 4'd0;
        overlap  = 1'b0;
        abort    = 1'b0;
        repeat (3) @(negedge clk);
        expQ.push_back(4'b0000);
        checkOutput("reset_state");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a frame clears outputs at once.
        @(negedge clk);
        start = 1'b1; repeat_n = 4'd3; overlap = 1'b0;
        @(negedge clk);
        start = 1'b0;
        expQ.push_back(4'b1110);
        checkOutput("pre_reset_bit");
        @(negedge clk);
        rst = 1'b0;
        #1;
        expQ.push_back(4'b0000);
        checkOutput("reset_mid_send");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expQ.push_back(4'b0000);
        checkOutput("idle_after_reset");

        applyStimulus(vecs[0], "after_reset");

        // Abort on the third bit of frame 2: outputs drop next cycle, no done.
        @(negedge clk);
        start = 1'b1; repeat_n = 4'd3; overlap = 1'b0;
        for (int i = 0; i < 8; i++) expQ.push_back({logic'(i == 0 || i == 4 || i == 5), 3'b110});
        for (int i = 0; i < 3; i++) expQ.push_back(4'b0000);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            checkOutput("abort_seq");
            start = 1'b0;
            abort = (c == 8);
        end
        abort = 1'b0;

        // start and abort together in IDLE must not launch a frame.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; repeat_n = 4'd1;
        expQ.push_back(4'b0000);
        expQ.push_back(4'b0000);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort_idle");
        @(negedge clk);
        checkOutput("start_abort_idle2");

        applyStimulus(vecs[2], "final_overlap");

        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
